// File: rtl/pe_acc_drain.sv
// Systolic MAC processing element: forwards operands and framing one hop per cycle,
// accumulates framed dot products and drains finished results through a column shift chain.
module pe_acc_drain #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              valid_in,
    input  logic              first_in,
    input  logic              last_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid_out,
    output logic              first_out,
    output logic              last_out,
    input  logic              load_en,
    input  logic              shift_en,
    input  logic [ACC_W-1:0]  res_in,
    input  logic              res_valid_in,
    output logic [ACC_W-1:0]  res_out,
    output logic              res_valid_out,
    output logic              ovf_out,
    output logic              overrun_out
);
    localparam int PW = 2 * DATA_W;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} pend_state_t;

    logic [ACC_W-1:0] acc, pend, base, result;
    logic [PW-1:0]    a_x, b_x, prod;
    logic [ACC_W:0]   prod_ext, base_ext, sum;
    logic             ovf_term, capture;
    pend_state_t      state;

    // Operands are extended to the full product width first, so one multiplier
    // serves both modes: the low PW bits are the correct signed or unsigned product.
    always_comb begin
        a_x = signed_mode ? {{DATA_W{a_in[DATA_W-1]}}, a_in} : {{DATA_W{1'b0}}, a_in};
        b_x = signed_mode ? {{DATA_W{b_in[DATA_W-1]}}, b_in} : {{DATA_W{1'b0}}, b_in};
        prod = a_x * b_x;
        prod_ext = signed_mode ? {{(ACC_W+1-PW){prod[PW-1]}}, prod}
                               : {{(ACC_W+1-PW){1'b0}}, prod};
        base = first_in ? '0 : acc;
        base_ext = signed_mode ? {base[ACC_W-1], base} : {1'b0, base};
        sum = base_ext + prod_ext;
        ovf_term = signed_mode ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        result = sum[ACC_W-1:0];
        if (SATURATE && ovf_term) begin
            if (!signed_mode)
                result = '1;
            else if (sum[ACC_W])
                result = {1'b1, {(ACC_W-1){1'b0}}};
            else
                result = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    assign capture = valid_in & last_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out     <= '0;
            b_out     <= '0;
            valid_out <= 1'b0;
            first_out <= 1'b0;
            last_out  <= 1'b0;
            acc       <= '0;
            ovf_out   <= 1'b0;
        end else begin
            valid_out <= valid_in;
            first_out <= valid_in & first_in;
            last_out  <= valid_in & last_in;
            if (valid_in) begin
                a_out   <= a_in;
                b_out   <= b_in;
                acc     <= result;
                ovf_out <= (first_in ? 1'b0 : ovf_out) | ovf_term;
            end
        end
    end

    // Pending buffer and result chain; load_en beats shift_en for the chain register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            pend          <= '0;
            res_out       <= '0;
            res_valid_out <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            if (capture)
                pend <= result;
            if (load_en) begin
                if (state == FULL) begin
                    res_out       <= pend;
                    res_valid_out <= 1'b1;
                end else begin
                    res_valid_out <= 1'b0;
                end
                state <= capture ? FULL : EMPTY;
            end else begin
                if (capture) begin
                    if (state == FULL)
                        overrun_out <= 1'b1;
                    state <= FULL;
                end
                if (shift_en) begin
                    res_out       <= res_in;
                    res_valid_out <= res_valid_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_acc_drain.sv
// Directed bench for pe_acc_drain: a saturating and a wrapping instance driven in lockstep.
module tb_pe_acc_drain;
    localparam int DW = 8;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          signed_mode = 1'b1;
    logic [DW-1:0] a_in = '0, b_in = '0;
    logic          valid_in = 1'b0, first_in = 1'b0, last_in = 1'b0;
    logic          load_en = 1'b0, shift_en = 1'b0;
    logic [AW-1:0] res_in = '0;
    logic          res_valid_in = 1'b0;

    logic [DW-1:0] a_out_s, b_out_s, a_out_w, b_out_w;
    logic          valid_out_s, first_out_s, last_out_s, valid_out_w, first_out_w, last_out_w;
    logic [AW-1:0] res_out_s, res_out_w;
    logic          res_valid_out_s, ovf_out_s, overrun_out_s;
    logic          res_valid_out_w, ovf_out_w, overrun_out_w;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pe_acc_drain #(.DATA_W(DW), .ACC_W(AW), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .signed_mode(signed_mode),
        .a_in(a_in), .b_in(b_in), .valid_in(valid_in), .first_in(first_in), .last_in(last_in),
        .a_out(a_out_s), .b_out(b_out_s), .valid_out(valid_out_s),
        .first_out(first_out_s), .last_out(last_out_s),
        .load_en(load_en), .shift_en(shift_en), .res_in(res_in), .res_valid_in(res_valid_in),
        .res_out(res_out_s), .res_valid_out(res_valid_out_s),
        .ovf_out(ovf_out_s), .overrun_out(overrun_out_s)
    );

    pe_acc_drain #(.DATA_W(DW), .ACC_W(AW), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .signed_mode(signed_mode),
        .a_in(a_in), .b_in(b_in), .valid_in(valid_in), .first_in(first_in), .last_in(last_in),
        .a_out(a_out_w), .b_out(b_out_w), .valid_out(valid_out_w),
        .first_out(first_out_w), .last_out(last_out_w),
        .load_en(load_en), .shift_en(shift_en), .res_in(res_in), .res_valid_in(res_valid_in),
        .res_out(res_out_w), .res_valid_out(res_valid_out_w),
        .ovf_out(ovf_out_w), .overrun_out(overrun_out_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic f, input logic l, input logic ld, input logic sh);
        valid_in = v; a_in = a; b_in = b; first_in = f; last_in = l;
        load_en = ld; shift_en = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic unload();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #12;
        check("rst_valid_out", {31'd0, valid_out_s}, 32'd0);
        check("rst_a_out", {24'd0, a_out_s}, 32'd0);
        check("rst_res_out", {12'd0, res_out_s}, 32'd0);
        check("rst_flags", {28'd0, res_valid_out_s, ovf_out_s, overrun_out_s, last_out_s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Signed frame: 12 - 10 - 7 = -5
        signed_mode = 1'b1;
        drive(1'b1, 8'd3, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fwd_first_out", {31'd0, first_out_s}, 32'd1);
        drive(1'b1, 8'hFE, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'd7, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fwd_last_out", {31'd0, last_out_s}, 32'd1);
        check("fwd_b_out", {24'd0, b_out_s}, 32'hFF);
        unload();
        check("signed_res", {12'd0, res_out_s}, 32'hFFFFB);
        check("signed_res_valid", {31'd0, res_valid_out_s}, 32'd1);
        check("signed_ovf", {31'd0, ovf_out_s}, 32'd0);

        // Unsigned: 16 x 255*255 fits, 17 overflows
        signed_mode = 1'b0;
        for (int i = 0; i < 16; i++)
            drive(1'b1, 8'd255, 8'd255, i == 0, i == 15, 1'b0, 1'b0);
        unload();
        check("u16_res", {12'd0, res_out_s}, 32'd1040400);
        check("u16_ovf", {31'd0, ovf_out_s}, 32'd0);
        for (int i = 0; i < 17; i++)
            drive(1'b1, 8'd255, 8'd255, i == 0, i == 16, 1'b0, 1'b0);
        unload();
        check("u17_sat_res", {12'd0, res_out_s}, 32'hFFFFF);
        check("u17_sat_ovf", {31'd0, ovf_out_s}, 32'd1);
        check("u17_wrap_res", {12'd0, res_out_w}, 32'd56849);
        check("u17_wrap_ovf", {31'd0, ovf_out_w}, 32'd1);
        drive(1'b1, 8'd2, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ovf_clear_first", {31'd0, ovf_out_s}, 32'd0);
        unload();
        check("single_term_res", {12'd0, res_out_s}, 32'd6);

        // Signed: 32 x (-128*127) fits, 33 clamps to the negative bound
        signed_mode = 1'b1;
        for (int i = 0; i < 32; i++)
            drive(1'b1, 8'h80, 8'h7F, i == 0, i == 31, 1'b0, 1'b0);
        unload();
        check("s32_res", {12'd0, res_out_s}, 32'h81000);
        check("s32_ovf", {31'd0, ovf_out_s}, 32'd0);
        for (int i = 0; i < 33; i++)
            drive(1'b1, 8'h80, 8'h7F, i == 0, i == 32, 1'b0, 1'b0);
        unload();
        check("s33_sat_res", {12'd0, res_out_s}, 32'h80000);
        check("s33_sat_ovf", {31'd0, ovf_out_s}, 32'd1);

        // Bubble in the middle of a frame
        drive(1'b1, 8'd10, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bub_valid_1", {31'd0, valid_out_s}, 32'd1);
        check("bub_a_1", {24'd0, a_out_s}, 32'd10);
        drive(1'b0, 8'd99, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("bub_valid_0", {31'd0, valid_out_s}, 32'd0);
        check("bub_a_hold", {24'd0, a_out_s}, 32'd10);
        check("bub_first_out", {31'd0, first_out_s}, 32'd0);
        drive(1'b1, 8'd20, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("bub_valid_2", {31'd0, valid_out_s}, 32'd1);
        check("bub_a_2", {24'd0, a_out_s}, 32'd20);
        unload();
        check("bub_res", {12'd0, res_out_s}, 32'd30);

        // Capture coinciding with load_en
        drive(1'b1, 8'd3, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'd4, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("coinc_res_old", {12'd0, res_out_s}, 32'd3);
        check("coinc_overrun", {31'd0, overrun_out_s}, 32'd0);
        unload();
        check("coinc_res_new", {12'd0, res_out_s}, 32'd4);
        check("coinc_res_valid", {31'd0, res_valid_out_s}, 32'd1);
        unload();
        check("empty_load_valid", {31'd0, res_valid_out_s}, 32'd0);
        check("empty_load_hold", {12'd0, res_out_s}, 32'd4);

        // Overrun: two captures with no unload
        drive(1'b1, 8'd5, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ovr_not_yet", {31'd0, overrun_out_s}, 32'd0);
        drive(1'b1, 8'd9, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ovr_set", {31'd0, overrun_out_s}, 32'd1);
        unload();
        check("ovr_res", {12'd0, res_out_s}, 32'd9);
        check("ovr_sticky", {31'd0, overrun_out_s}, 32'd1);

        // Chain shifting and load priority
        res_in = 20'h00ABC; res_valid_in = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("shift_res", {12'd0, res_out_s}, 32'h00ABC);
        check("shift_valid", {31'd0, res_valid_out_s}, 32'd1);
        drive(1'b1, 8'd7, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("load_prio_res", {12'd0, res_out_s}, 32'd7);
        res_in = 20'h00123; res_valid_in = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("shift_res2", {12'd0, res_out_s}, 32'h00123);
        check("shift_valid2", {31'd0, res_valid_out_s}, 32'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("chain_hold", {12'd0, res_out_s}, 32'h00123);

        // Asynchronous reset mid-frame, then a non-first term starts from zero
        drive(1'b1, 8'd3, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid_out", {31'd0, valid_out_s}, 32'd0);
        check("arst_a_out", {24'd0, a_out_s}, 32'd0);
        check("arst_res_out", {12'd0, res_out_s}, 32'd0);
        check("arst_flags", {29'd0, ovf_out_s, overrun_out_s, first_out_s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 8'd2, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        unload();
        check("arst_restart_res", {12'd0, res_out_s}, 32'd6);
        check("arst_restart_valid", {31'd0, res_valid_out_s}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
